// File: rtl/ddr3_udp_fragmenter_if.sv
// Signal bundle between the DDR3 frame fragmenter, its read port, frame source and UDP sender.
// slave: the fragmenter itself; master: the surrounding environment that drives the i_* side.
interface ddr3_udp_fragmenter_if #(
    parameter int DATA_W = 128,
    parameter int CH_NUM = 2,
    parameter int CHW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
);
    logic              i_en;
    logic [CHW-1:0]    i_ch;
    logic [23:0]       i_addr;
    logic [24:0]       i_frame_len_b;
    logic              o_busy;
    logic              o_error;
    logic              o_rd_req;
    logic [23:0]       o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;
    logic              i_rd_valid;
    logic              o_udp_en;
    logic [15:0]       o_udp_len;
    logic              o_udp_last;
    logic [14:0]       o_udp_rank;
    logic [15:0]       o_udp_ident;
    logic [CHW-1:0]    o_udp_ch;
    logic [DATA_W-1:0] o_udp_data;
    logic              i_udp_data_req;
    logic              i_udp_busy;

    modport slave (
        input  i_en, i_ch, i_addr, i_frame_len_b, i_rd_data, i_rd_valid,
               i_udp_data_req, i_udp_busy,
        output o_busy, o_error, o_rd_req, o_rd_addr, o_udp_en, o_udp_len,
               o_udp_last, o_udp_rank, o_udp_ident, o_udp_ch, o_udp_data
    );

    modport master (
        output i_en, i_ch, i_addr, i_frame_len_b, i_rd_data, i_rd_valid,
               i_udp_data_req, i_udp_busy,
        input  o_busy, o_error, o_rd_req, o_rd_addr, o_udp_en, o_udp_len,
               o_udp_last, o_udp_rank, o_udp_ident, o_udp_ch, o_udp_data
    );
endinterface

// File: rtl/ddr3_udp_fragmenter.sv
// Splits a DDR3-resident frame into UDP payload packets, prefetching read beats into a small FIFO.
// Packet sequencing and read prefetch run independently; only FIFO occupancy couples them.
module ddr3_udp_fragmenter #(
    parameter int DATA_W        = 128,
    parameter int MAX_PAYLOAD_B = 1456,
    parameter int PF_DEPTH      = 4,
    parameter int CH_NUM        = 2,
    parameter int CHW           = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input logic                   i_pclk84m,
    input logic                   i_rst_n,
    ddr3_udp_fragmenter_if.slave  bus
);
    localparam int BEAT_B = DATA_W / 8;
    localparam int PTR_W  = $clog2(PF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE_WAIT} state_t;

    state_t            state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic              ubusy_prev_q, ubusy_prev_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [24:0]       rem_q, rem_d;
    logic [24:0]       beats_left_q, beats_left_d;
    logic [23:0]       nxt_addr_q, nxt_addr_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [15:0]       ident_q [CH_NUM];
    logic [15:0]       ident_d [CH_NUM];
    logic              busy_q, busy_d;
    logic              error_q, error_d;
    logic              rd_req_q, rd_req_d;
    logic [23:0]       rd_addr_q, rd_addr_d;
    logic              udp_en_q, udp_en_d;
    logic [15:0]       udp_len_q, udp_len_d;
    logic              udp_last_q, udp_last_d;
    logic [14:0]       udp_rank_q, udp_rank_d;
    logic [15:0]       udp_ident_q, udp_ident_d;
    logic [CHW-1:0]    udp_ch_q, udp_ch_d;

    logic [DATA_W-1:0] fifo_mem [PF_DEPTH];

    logic              rise_en, fall_ubusy, issue, rsp_ok, push, pop, flush;
    logic [24:0]       len_beats;

    // Occupancy plus in-flight requests never exceeds PF_DEPTH, so a push always has room.
    always_comb begin
        rise_en    = bus.i_en & ~en_prev_q;
        fall_ubusy = ubusy_prev_q & ~bus.i_udp_busy;
        len_beats  = 25'((26'(bus.i_frame_len_b) + 26'(BEAT_B - 1)) / 26'(BEAT_B));
        issue      = (state_q != IDLE) && (beats_left_q != '0) &&
                     (({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < (CNT_W + 1)'(PF_DEPTH));
        rsp_ok     = bus.i_rd_valid && (out_cnt_q != '0);
        push       = rsp_ok && (state_q != IDLE);
        pop        = bus.i_udp_data_req && (fifo_cnt_q != '0);
        flush      = 1'b0;

        state_d      = state_q;
        en_prev_d    = bus.i_en;
        ubusy_prev_d = bus.i_udp_busy;
        ch_d         = ch_q;
        rem_d        = rem_q;
        beats_left_d = beats_left_q;
        nxt_addr_d   = nxt_addr_q;
        ident_d      = ident_q;
        busy_d       = busy_q;
        error_d      = error_q;
        rd_req_d     = 1'b0;
        rd_addr_d    = rd_addr_q;
        udp_en_d     = 1'b0;
        udp_len_d    = udp_len_q;
        udp_last_d   = udp_last_q;
        udp_rank_d   = udp_rank_q;
        udp_ident_d  = udp_ident_q;
        udp_ch_d     = udp_ch_q;

        if (issue) begin
            rd_req_d     = 1'b1;
            rd_addr_d    = nxt_addr_q;
            nxt_addr_d   = nxt_addr_q + 24'd1;
            beats_left_d = beats_left_q - 25'd1;
        end
        out_cnt_d = out_cnt_q + CNT_W'(issue) - CNT_W'(rsp_ok);

        if (bus.i_rd_valid && (out_cnt_q == '0))
            error_d = 1'b1;
        if (bus.i_udp_data_req && (fifo_cnt_q == '0))
            error_d = 1'b1;
        if (rise_en && (state_q != IDLE))
            error_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (rise_en) begin
                    if (bus.i_frame_len_b == '0) begin
                        error_d = 1'b1;
                    end else begin
                        ch_d         = bus.i_ch;
                        nxt_addr_d   = bus.i_addr;
                        rem_d        = bus.i_frame_len_b;
                        beats_left_d = len_beats;
                        busy_d       = 1'b1;
                        state_d      = LOAD;
                    end
                end
            end
            LOAD: begin
                udp_en_d       = 1'b1;
                udp_ch_d       = ch_q;
                udp_rank_d     = udp_rank_q + 15'd1;
                ident_d[ch_q]  = ident_q[ch_q] + 16'd1;
                udp_ident_d    = ident_q[ch_q] + 16'd1;
                if (rem_q > 25'(MAX_PAYLOAD_B)) begin
                    udp_len_d  = 16'(MAX_PAYLOAD_B);
                    rem_d      = rem_q - 25'(MAX_PAYLOAD_B);
                    udp_last_d = 1'b0;
                    state_d    = XFER;
                end else begin
                    udp_len_d  = rem_q[15:0];
                    rem_d      = '0;
                    udp_last_d = 1'b1;
                    state_d    = DONE_WAIT;
                end
            end
            XFER: begin
                if (fall_ubusy)
                    state_d = LOAD;
            end
            DONE_WAIT: begin
                if (fall_ubusy) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    udp_rank_d = '0;
                    flush      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        if (flush) begin
            fifo_cnt_d = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge i_pclk84m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            en_prev_q    <= 1'b0;
            ubusy_prev_q <= 1'b0;
            ch_q         <= '0;
            rem_q        <= '0;
            beats_left_q <= '0;
            nxt_addr_q   <= '0;
            out_cnt_q    <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < CH_NUM; i++)
                ident_q[i] <= '0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            udp_en_q     <= 1'b0;
            udp_len_q    <= '0;
            udp_last_q   <= 1'b0;
            udp_rank_q   <= '0;
            udp_ident_q  <= '0;
            udp_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            en_prev_q    <= en_prev_d;
            ubusy_prev_q <= ubusy_prev_d;
            ch_q         <= ch_d;
            rem_q        <= rem_d;
            beats_left_q <= beats_left_d;
            nxt_addr_q   <= nxt_addr_d;
            out_cnt_q    <= out_cnt_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ident_q      <= ident_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            udp_en_q     <= udp_en_d;
            udp_len_q    <= udp_len_d;
            udp_last_q   <= udp_last_d;
            udp_rank_q   <= udp_rank_d;
            udp_ident_q  <= udp_ident_d;
            udp_ch_q     <= udp_ch_d;
        end
    end

    // Storage needs no reset: occupancy and pointers alone define what is valid.
    always_ff @(posedge i_pclk84m) begin
        if (push)
            fifo_mem[wr_ptr_q] <= bus.i_rd_data;
    end

    assign bus.o_udp_data  = fifo_mem[rd_ptr_q];
    assign bus.o_busy      = busy_q;
    assign bus.o_error     = error_q;
    assign bus.o_rd_req    = rd_req_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_udp_en    = udp_en_q;
    assign bus.o_udp_len   = udp_len_q;
    assign bus.o_udp_last  = udp_last_q;
    assign bus.o_udp_rank  = udp_rank_q;
    assign bus.o_udp_ident = udp_ident_q;
    assign bus.o_udp_ch    = udp_ch_q;
endmodule

// File: tb/tb_ddr3_udp_fragmenter.sv
// Bench for ddr3_udp_fragmenter: randomized DDR3 latency and sink pacing against a frame-level model.
module tb_ddr3_udp_fragmenter;
    localparam int DATA_W = 128;
    localparam int BEAT_B = DATA_W / 8;
    localparam int MAXP   = 1456;
    localparam int PF     = 4;
    localparam int CHW    = 1;

    typedef struct {
        int len;
        int last;
        int rank;
        int ident;
        int ch;
    } pkt_t;

    logic clk;
    logic rst_n;

    ddr3_udp_fragmenter_if #(.DATA_W(DATA_W), .CH_NUM(2)) bus ();

    ddr3_udp_fragmenter #(
        .DATA_W(DATA_W), .MAX_PAYLOAD_B(MAXP), .PF_DEPTH(PF), .CH_NUM(2)
    ) dut (
        .i_pclk84m (clk),
        .i_rst_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #6 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ident_m [2];

    // environment state: written only by the environment process
    logic [23:0]       rd_addrs [$];
    logic [DATA_W-1:0] pops [$];
    pkt_t              pkts [$];
    logic [23:0]       pend_addr [$];
    int                pend_due [$];
    int                cyc, pushed, popped, pkt_beats, clear_seen, pop_seen;
    bit                pkt_active;

    // control from the test sequence: written only by the main process
    int clear_req = 0;
    int pop_req   = 0;
    bit sink_auto = 1'b1;

    function automatic logic [DATA_W-1:0] beat(input logic [23:0] a);
        return {a, 8'hC3, a ^ 24'h5A5A5A, 8'h3C, a + 24'h13579B, 8'h96, ~a, 8'h69};
    endfunction

    // DDR3 responder and UDP sink
    initial begin
        pkt_t p;
        cyc = 0; pushed = 0; popped = 0; pkt_beats = 0; pkt_active = 1'b0;
        clear_seen = 0; pop_seen = 0;
        bus.i_rd_valid = 1'b0; bus.i_rd_data = '0;
        bus.i_udp_data_req = 1'b0; bus.i_udp_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (clear_req != clear_seen) begin
                clear_seen = clear_req;
                pend_addr.delete(); pend_due.delete();
                pushed = 0; popped = 0; pkt_beats = 0; pkt_active = 1'b0;
                bus.i_rd_valid = 1'b0; bus.i_udp_data_req = 1'b0; bus.i_udp_busy = 1'b0;
            end else begin
                if (bus.i_rd_valid) pushed++;
                if (bus.i_udp_data_req) popped++;
                bus.i_rd_valid = 1'b0;
                bus.i_udp_data_req = 1'b0;
                if (bus.o_rd_req) begin
                    rd_addrs.push_back(bus.o_rd_addr);
                    pend_addr.push_back(bus.o_rd_addr);
                    pend_due.push_back(cyc + int'($urandom_range(1, 4)));
                end
                if (bus.o_udp_en) begin
                    p.len = int'(bus.o_udp_len); p.last = int'(bus.o_udp_last);
                    p.rank = int'(bus.o_udp_rank); p.ident = int'(bus.o_udp_ident);
                    p.ch = int'(bus.o_udp_ch);
                    pkts.push_back(p);
                    pkt_beats = (p.len + BEAT_B - 1) / BEAT_B;
                    pkt_active = 1'b1;
                end
                if (pkt_active && sink_auto) begin
                    if (!bus.i_udp_busy) begin
                        bus.i_udp_busy = 1'b1;
                    end else if (pkt_beats > 0) begin
                        if ((pushed - popped) > 0 && $urandom_range(0, 3) != 0) begin
                            pops.push_back(bus.o_udp_data);
                            bus.i_udp_data_req = 1'b1;
                            pkt_beats--;
                        end
                    end else if ($urandom_range(0, 1) == 1) begin
                        bus.i_udp_busy = 1'b0;
                        pkt_active = 1'b0;
                    end
                end
                if (pop_req != pop_seen) begin
                    pop_seen = pop_req;
                    bus.i_udp_data_req = 1'b1;
                end
                if (pend_addr.size() > 0 && cyc >= pend_due[0]) begin
                    bus.i_rd_valid = 1'b1;
                    bus.i_rd_data = beat(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
            end
        end
    end

    function automatic logic [76:0] out_snap();
        return {bus.o_busy, bus.o_error, bus.o_rd_req, bus.o_udp_en, bus.o_udp_last,
                bus.o_udp_rank, bus.o_udp_len, bus.o_udp_ident, bus.o_udp_ch, bus.o_rd_addr};
    endfunction

    task automatic apply_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        clear_req++;
        ident_m[0] = 0; ident_m[1] = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic start_frame(input int ch, input logic [23:0] addr, input int len);
        @(posedge clk); #2;
        bus.i_ch = CHW'(ch); bus.i_addr = addr; bus.i_frame_len_b = 25'(len);
        bus.i_en = 1'b1;
        @(posedge clk); #2;
        bus.i_en = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bus.o_busy === 1'b1 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s timeout: o_busy=%b after %0d cycles, want 0", name, bus.o_busy, n);
        end
    endtask

    // Runs one frame end to end and checks reads, popped data and packet headers against the model.
    task automatic run_frame(input int ch, input logic [23:0] addr, input int len,
                             input string name, input int hold);
        int s_rd, s_pop, s_pk, nb, rem, first_bad, last;
        int exp_len [$];
        pkt_t p;
        s_rd = rd_addrs.size(); s_pop = pops.size(); s_pk = pkts.size();
        rem = len;
        while (rem > MAXP) begin exp_len.push_back(MAXP); rem -= MAXP; end
        exp_len.push_back(rem);
        nb = (len + BEAT_B - 1) / BEAT_B;

        if (hold > 0) sink_auto = 1'b0;
        start_frame(ch, addr, len);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #2;
            total++;
            if (rd_addrs.size() - s_rd != ((nb < PF) ? nb : PF)) begin
                bad++;
                $display("FAIL %s stalled reads: got %0d want %0d", name,
                         rd_addrs.size() - s_rd, (nb < PF) ? nb : PF);
            end
            sink_auto = 1'b1;
        end
        wait_idle(8000, name);
        repeat (8) @(posedge clk);
        #2;

        total++;
        if (rd_addrs.size() - s_rd != nb) begin
            bad++;
            $display("FAIL %s read count: got %0d want %0d", name, rd_addrs.size() - s_rd, nb);
        end
        first_bad = -1;
        for (int i = 0; i < nb && s_rd + i < rd_addrs.size(); i++)
            if (first_bad < 0 && rd_addrs[s_rd + i] !== addr + 24'(i)) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s read addr[%0d]: got %06h want %06h", name, first_bad,
                     rd_addrs[s_rd + first_bad], addr + 24'(first_bad));
        end

        total++;
        if (pops.size() - s_pop != nb) begin
            bad++;
            $display("FAIL %s pop count: got %0d want %0d", name, pops.size() - s_pop, nb);
        end
        first_bad = -1;
        for (int i = 0; i < nb && s_pop + i < pops.size(); i++)
            if (first_bad < 0 && pops[s_pop + i] !== beat(addr + 24'(i))) first_bad = i;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s data[%0d]: got %h want %h", name, first_bad,
                     pops[s_pop + first_bad], beat(addr + 24'(first_bad)));
        end

        total++;
        if (pkts.size() - s_pk != exp_len.size()) begin
            bad++;
            $display("FAIL %s packet count: got %0d want %0d", name, pkts.size() - s_pk, exp_len.size());
        end
        for (int i = 0; i < exp_len.size(); i++) begin
            ident_m[ch] = (ident_m[ch] + 1) % 65536;
            last = (i == exp_len.size() - 1) ? 1 : 0;
            if (s_pk + i < pkts.size()) begin
                p = pkts[s_pk + i];
                total++;
                if (p.len != exp_len[i] || p.last != last || p.rank != i + 1 ||
                    p.ident != ident_m[ch] || p.ch != ch) begin
                    bad++;
                    $display("FAIL %s pkt%0d: got len=%0d last=%0d rank=%0d ident=%0d ch=%0d want len=%0d last=%0d rank=%0d ident=%0d ch=%0d",
                             name, i, p.len, p.last, p.rank, p.ident, p.ch,
                             exp_len[i], last, i + 1, ident_m[ch], ch);
                end
            end
        end

        total++;
        if (bus.o_error !== 1'b0 || bus.o_udp_rank !== 15'd0) begin
            bad++;
            $display("FAIL %s end state: got error=%b rank=%0d want error=0 rank=0",
                     name, bus.o_error, bus.o_udp_rank);
        end
    endtask

    task automatic test_reset();
        int s_pk;
        rst_n = 1'b0;
        bus.i_en = 1'b0; bus.i_ch = '0; bus.i_addr = '0; bus.i_frame_len_b = '0;
        clear_req++;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (out_snap() !== '0) begin
            bad++;
            $display("FAIL reset outputs: got %h want 0", out_snap());
        end
        // i_en already high when reset releases must start a frame
        s_pk = pkts.size();
        bus.i_ch = 1'b0; bus.i_addr = 24'h000010; bus.i_frame_len_b = 25'd16; bus.i_en = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #2;
        total++;
        if (bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL en high at release: o_busy=%b want 1", bus.o_busy);
        end
        bus.i_en = 1'b0;
        wait_idle(500, "en_at_release");
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (pkts.size() - s_pk != 1 || (pkts.size() > s_pk && pkts[s_pk].len != 16)) begin
            bad++;
            $display("FAIL en at release packet: got count=%0d want count=1 len=16", pkts.size() - s_pk);
        end
    endtask

    task automatic test_single_packet();
        apply_reset();
        run_frame(0, 24'h000100, 1456, "single", 0);
        total++;
        if (rd_addrs[rd_addrs.size() - 1] !== 24'h00015A || pkts[pkts.size() - 1].ident != 1) begin
            bad++;
            $display("FAIL single tail: got last addr=%06h ident=%0d want 00015a ident=1",
                     rd_addrs[rd_addrs.size() - 1], pkts[pkts.size() - 1].ident);
        end
    endtask

    task automatic test_multi_packet();
        run_frame(1, 24'($urandom), 3000, "multi", 0);
    endtask

    task automatic test_channels();
        int s_pk;
        apply_reset();
        s_pk = pkts.size();
        run_frame(0, 24'($urandom), 200, "chan_a", 0);
        run_frame(1, 24'($urandom), 1000, "chan_b", 0);
        run_frame(0, 24'($urandom), 48, "chan_c", 0);
        total++;
        if (pkts.size() - s_pk != 3 || pkts[s_pk].ident != 1 || pkts[s_pk + 1].ident != 1 ||
            pkts[s_pk + 2].ident != 2) begin
            bad++;
            $display("FAIL channel idents: got count=%0d want idents 1,1,2", pkts.size() - s_pk);
        end
    endtask

    task automatic test_boundaries();
        int lens [8] = '{1, 16, 17, 1455, 1456, 1457, 2912, 2913};
        foreach (lens[i])
            run_frame(int'($urandom_range(0, 1)), 24'($urandom), lens[i], "boundary", 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_frame(int'($urandom_range(0, 1)), 24'($urandom),
                      int'($urandom_range(1, 5000)), "random", 0);
    endtask

    task automatic test_stall();
        run_frame(0, 24'($urandom), 3000, "stall", 60);
    endtask

    task automatic test_errors();
        int s_pk;
        apply_reset();
        @(posedge clk); #2;
        total++;
        if (bus.o_error !== 1'b0) begin
            bad++;
            $display("FAIL error clear after reset: got %b want 0", bus.o_error);
        end
        pop_req++;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (bus.o_error !== 1'b1) begin
            bad++;
            $display("FAIL pop on empty: o_error=%b want 1", bus.o_error);
        end
        repeat (20) @(posedge clk);
        #2;
        total++;
        if (bus.o_error !== 1'b1) begin
            bad++;
            $display("FAIL error sticky: o_error=%b want 1", bus.o_error);
        end

        apply_reset();
        start_frame(0, 24'h000200, 0);
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL zero length: got error=%b busy=%b want error=1 busy=0", bus.o_error, bus.o_busy);
        end

        apply_reset();
        s_pk = pkts.size();
        start_frame(1, 24'h000400, 3000);
        repeat (30) @(posedge clk);
        #2 bus.i_en = 1'b1;
        @(posedge clk); #2 bus.i_en = 1'b0;
        @(posedge clk); #2;
        total++;
        if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL en while busy: got error=%b busy=%b want error=1 busy=1", bus.o_error, bus.o_busy);
        end
        wait_idle(8000, "en_while_busy");
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (pkts.size() - s_pk != 3) begin
            bad++;
            $display("FAIL en while busy packets: got %0d want 3", pkts.size() - s_pk);
        end
    endtask

    task automatic test_reset_midframe();
        int s_rd;
        apply_reset();
        sink_auto = 1'b0;
        start_frame(1, 24'hFFFFFE, 64);
        repeat (12) @(posedge clk);
        #2;
        total++;
        if (bus.o_busy !== 1'b1 || bus.o_udp_rank !== 15'd1) begin
            bad++;
            $display("FAIL midframe before reset: got busy=%b rank=%0d want busy=1 rank=1",
                     bus.o_busy, bus.o_udp_rank);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        clear_req++;
        ident_m[0] = 0; ident_m[1] = 0;
        #1;
        total++;
        if (out_snap() !== '0) begin
            bad++;
            $display("FAIL midframe reset outputs: got %h want 0", out_snap());
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        sink_auto = 1'b1;
        s_rd = rd_addrs.size();
        run_frame(1, 24'hFFFFFE, 64, "rerun", 0);
        total++;
        if (rd_addrs.size() - s_rd != 4 || rd_addrs[s_rd] !== 24'hFFFFFE ||
            rd_addrs[s_rd + 1] !== 24'hFFFFFF || rd_addrs[s_rd + 2] !== 24'h000000 ||
            rd_addrs[s_rd + 3] !== 24'h000001) begin
            bad++;
            $display("FAIL rerun wrap: got %0d reads want fffffe,ffffff,000000,000001", rd_addrs.size() - s_rd);
        end
    endtask

    initial begin
        ident_m[0] = 0; ident_m[1] = 0;
        test_reset();
        test_single_packet();
        test_multi_packet();
        test_channels();
        test_boundaries();
        test_random();
        test_stall();
        test_errors();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
